// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle controller: instruction bits and
// status flags in, datapath strobes and selects out.
interface multicycle_ctrl_if;
  logic [10:0] op;
  logic        alu_zero;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        reg_write;
  logic        mem_to_reg;
  logic        alu_src;
  logic        reg2loc;
  logic        pc_src;
  logic [1:0]  alu_op;
  logic [1:0]  imm_sel;

  modport master (
    input  op, alu_zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, iord, reg_write,
           mem_to_reg, alu_src, reg2loc, pc_src, alu_op, imm_sel
  );

  modport slave (
    output op, alu_zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, iord, reg_write,
           mem_to_reg, alu_src, reg2loc, pc_src, alu_op, imm_sel
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle controller for a small LEGv8 subset (LDUR/STUR/CBZ/MOVZ/R-type):
// FETCH/DECODE/EXEC/MEM/WB sequencing, sticky illegal trap and retire counter.
module multicycle_ctrl #(
  parameter int CW = 32
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus,
  output logic [2:0]        state,
  output logic              illegal,
  output logic [CW-1:0]     instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_LDUR = 3'd1,
    C_STUR = 3'd2,
    C_CBZ  = 3'd3,
    C_MOVZ = 3'd4,
    C_ILL  = 3'd5
  } class_t;

  state_t          state_reg, state_next;
  class_t          class_reg, dec_class;
  logic            illegal_reg;
  logic [CW-1:0]   instret_reg;
  logic            retire;

  always_comb begin
    dec_class = C_ILL;
    casez (bus.op)
      11'b11111000010: dec_class = C_LDUR;
      11'b11111000000: dec_class = C_STUR;
      11'b10110100???: dec_class = C_CBZ;
      11'b110100101??: dec_class = C_MOVZ;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: dec_class = C_R;
      default:         dec_class = C_ILL;
    endcase
  end

  // Class is latched once at DECODE so later phases ignore a changing op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      class_reg   <= C_R;
      illegal_reg <= 1'b0;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        class_reg <= dec_class;
      end
      if (state_next == S_ERR) begin
        illegal_reg <= 1'b1;
      end
      if (retire) begin
        instret_reg <= instret_reg + CW'(1);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    retire         = 1'b0;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src    = 1'b0;
    bus.reg2loc    = 1'b0;
    bus.pc_src     = 1'b0;
    bus.alu_op     = 2'b00;
    bus.imm_sel    = 2'b00;

    case (state_reg)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = (dec_class == C_ILL) ? S_ERR : S_EXEC;
      end
      S_EXEC: begin
        case (class_reg)
          C_R: begin
            bus.alu_op = 2'b10;
            state_next = S_WB;
          end
          C_LDUR, C_STUR: begin
            bus.alu_src = 1'b1;
            bus.reg2loc = (class_reg == C_STUR);
            state_next  = S_MEM;
          end
          C_CBZ: begin
            bus.alu_op   = 2'b01;
            bus.reg2loc  = 1'b1;
            bus.imm_sel  = 2'b01;
            bus.pc_src   = 1'b1;
            bus.pc_write = bus.alu_zero;
            retire       = 1'b1;
            state_next   = S_FETCH;
          end
          C_MOVZ: begin
            bus.alu_src = 1'b1;
            bus.alu_op  = 2'b11;
            bus.imm_sel = 2'b10;
            state_next  = S_WB;
          end
          default: state_next = S_ERR;
        endcase
      end
      S_MEM: begin
        bus.iord      = 1'b1;
        bus.mem_read  = (class_reg == C_LDUR);
        bus.mem_write = (class_reg != C_LDUR);
        if (bus.mem_ready) begin
          if (class_reg == C_LDUR) begin
            state_next = S_WB;
          end else begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (class_reg == C_LDUR);
        retire         = 1'b1;
        state_next     = S_FETCH;
      end
      S_ERR: state_next = S_ERR;
      default: state_next = S_ERR;
    endcase

    // Reset must silence the datapath combinationally, aborting any access.
    if (reset) begin
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.iord      = 1'b0;
      bus.reg_write = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src   = 1'b0;
      bus.reg2loc   = 1'b0;
      bus.pc_src    = 1'b0;
      bus.alu_op    = 2'b00;
      bus.imm_sel   = 2'b00;
      retire        = 1'b0;
    end
  end

  assign state   = state_reg;
  assign illegal = illegal_reg;
  assign instret = instret_reg;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CW, 32, width of retired-instruction counter.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port op  in  11  instruction bits [31:21] from the instruction register.
REQ-005 SHALL have port alu_zero  in  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  in  1  memory access completes this cycle.
REQ-007 SHALL have outputs pc_write, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, alu_src, reg2loc, pc_src, each  out  1  datapath strobes and selects (iord 0=PC, 1=ALU result; pc_src 0=PC+4, 1=branch target).
REQ-008 SHALL have port alu_op  out  2  00 add, 01 pass-B/zero test, 10 R-type funct, 11 pass immediate.
REQ-009 SHALL have port imm_sel  out  2  extender format: 00 D-type, 01 CB-type, 10 MOVZ.
REQ-010 SHALL have port state  out  3  current FSM state encoding.
REQ-011 SHALL have port illegal  out  1  sticky illegal-opcode flag.
REQ-012 SHALL have port instret  out  CW  count of retired instructions.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5; codes 6-7 SHALL go to ERR.
REQ-014 SHALL classify op in DECODE: LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, MOVZ 110100101xx, R-type ADD 10001011000 / SUB 11001011000 / AND 10001010000 / ORR 10101010000; anything else illegal.
REQ-015 SHALL register the class at the DECODE->EXEC edge and drive all EXEC/MEM/WB outputs from the registered class, not from op.
REQ-016 FETCH: mem_read=1, iord=0; hold while mem_ready=0; when mem_ready=1 assert ir_write=1, pc_write=1, pc_src=0 that cycle and go DECODE.
REQ-017 DECODE: no strobes; legal -> EXEC; illegal -> ERR.
REQ-018 EXEC R-type: alu_src=0, alu_op=10, reg2loc=0 -> WB.
REQ-019 EXEC LDUR/STUR: alu_src=1, alu_op=00, imm_sel=00, reg2loc=1 for STUR -> MEM.
REQ-020 EXEC CBZ: alu_src=0, alu_op=01, reg2loc=1, imm_sel=01; pc_src=1 and pc_write=alu_zero in that same cycle; -> FETCH; instruction retires.
REQ-021 EXEC MOVZ: alu_src=1, alu_op=11, imm_sel=10 -> WB.
REQ-022 MEM: iord=1; mem_read=1 (LDUR) or mem_write=1 (STUR); hold while mem_ready=0; on mem_ready=1 LDUR -> WB, STUR -> FETCH and retires.
REQ-023 WB: reg_write=1 for exactly one cycle, mem_to_reg=1 only for LDUR -> FETCH; instruction retires.
REQ-024 Retire SHALL increment instret by 1 on the retiring edge, wrapping from 2^CW-1 to 0.
REQ-025 ERR: all strobes 0, illegal=1, state held until reset.
REQ-026 Outside the states listed per signal, every strobe SHALL be 0; mem_read and mem_write SHALL never both be 1.
REQ-027 pc_write SHALL be asserted at most once per instruction except CBZ taken (FETCH and EXEC).

Reset
REQ-028 reset=1 SHALL immediately force state=FETCH, class=R-type, illegal=0, instret=0, independent of clk.
REQ-029 With reset=1 all strobes SHALL be 0; first FETCH strobes appear in the first cycle after deassertion.
REQ-030 Reset mid-MEM or mid-FETCH SHALL abort the access: mem_read/mem_write drop in the same cycle reset rises.

Verification
REQ-031 ADD (op=10001011000), mem_ready always 1 -> states 0,1,2,4,0; reg_write=1 in WB only; instret 0->1 after 4 cycles.
REQ-032 LDUR with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_read=1 iord=1 throughout, then WB with mem_to_reg=1; instret +1.
REQ-033 CBZ with alu_zero=1 then alu_zero=0 -> pc_write=1,pc_src=1 in EXEC first time, pc_write=0 second; each takes 3 cycles; instret +2.
REQ-034 op=00000000000 -> DECODE->ERR, illegal=1 held for 10 cycles, no strobes; reset clears to FETCH, illegal=0.
REQ-035 STUR then MOVZ -> STUR: mem_write=1 in MEM, never reg_write; MOVZ: imm_sel=10, alu_op=11, reg_write=1 in WB.
REQ-036 Preload instret=2^CW-1 via back-to-back ADDs (CW=4: 15 retires) -> 16th retire wraps instret to 0.
